s3g_rx_dbuf: RTL and testbench
==============================

# s3g_rx_dbuf

Parametrised, double-buffered S3G packet receiver.
- Takes the byte strobe from the host UART, frames packets of the form start byte, length, payload, CRC-8 (Maxim/iButton).
- Holds up to two complete, CRC-checked payloads for the command executor.
- Reports framing, CRC, timeout and overrun errors as coded pulses.
- Sits between `uart_transceiver` and the S3G/buffer executors. It lets a new packet stream in while the previous one is still being executed.

## Interface
Parameters:
- `MAX_PAYLOAD`, 32: largest accepted payload in bytes, range 1..255.
- `TIMEOUT_CYCLES`, 50000: idle clocks between bytes that abort a packet in progress.
- `START_BYTE`, 8'hD5: frame start marker.
- `AW`, $clog2(MAX_PAYLOAD): payload address width, derived.

Ports:
- `clk` in 1: system clock. The block has one clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 8: received byte.
- `in_valid` in 1: one-cycle strobe. There is no backpressure.
- `pkt_valid` out 1: front buffer holds a good packet.
- `pkt_ready` in 1: executor retires the front packet.
- `pkt_len` out 8: payload length of the front packet.
- `rd_addr` in AW: payload byte index.
- `rd_data` out 8: byte of the front buffer at `rd_addr`. Combinational read.
- `err_valid` out 1: one-cycle error pulse.
- `err_code` out 2: error code. 0 = CRC mismatch, 1 = bad length, 2 = timeout, 3 = overrun.
- `busy` out 1: a packet is currently being received.

## Operation
- State machine has five states: IDLE, LEN, PAYLOAD, CRC, SKIP.
- IDLE:
  - Bytes other than `START_BYTE` are ignored.
  - On `START_BYTE` with a free buffer: latch that buffer as the write buffer, clear the CRC to 8'h00, go to LEN.
  - On `START_BYTE` with no free buffer: go to SKIP with overrun pending.
- LEN:
  - Length 0 or greater than `MAX_PAYLOAD`: emit `err_code`=1 and return to IDLE.
  - Otherwise store the length and go to PAYLOAD.
- PAYLOAD:
  - Each byte is written to the write buffer at an incrementing index.
  - CRC update per byte: reflected polynomial 0x8C, i.e. Maxim x^8+x^5+x^4+1.
  - After `len` bytes, go to CRC.
- CRC:
  - Byte equals the computed CRC: mark the write buffer full and queue it behind any packet already pending.
  - Mismatch: emit `err_code`=0 and leave the buffer free.
  - Return to IDLE in both cases.
- SKIP: if `len` is valid, discard the length byte plus `len+1` further bytes, then emit `err_code`=3; if the length is invalid, emit `err_code`=3 immediately. Return to IDLE.
- Timeout:
  - A counter resets on every `in_valid` and runs only outside IDLE.
  - Reaching `TIMEOUT_CYCLES`: emit `err_code`=2, return to IDLE, discard the partial packet.
- Buffers:
  - Two buffers of `MAX_PAYLOAD` bytes each, served in ping-pong FIFO order.
  - `pkt_valid` = front buffer full.
  - `pkt_valid && pkt_ready` frees the front buffer and advances the front pointer.
  - `pkt_ready` while `pkt_valid`=0 is ignored.
- `busy` = state != IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `pkt_valid`=0, `pkt_len`=0, `err_valid`=0, `err_code`=0, `busy`=0.
  - Both buffers marked free; buffer data is not reset.
- Latency:
  - `pkt_valid` rises in the cycle after the good CRC byte's `in_valid`, if no older packet is pending.
  - Errors pulse `err_valid` in the cycle after the offending byte or timeout.
- Retire: `pkt_valid` drops the cycle after the handshake, unless the second buffer is full. In that case it stays high and `pkt_len`/`rd_data` switch to the next packet.
- Simultaneous events:
  - Start byte and retire in the same cycle: the freed buffer does not count as free. This gives an overrun.
  - CRC commit and retire in the same cycle: both take effect.
- `err_valid` is never asserted in two consecutive cycles except for distinct events.
- Asynchronous reset mid-packet: partial and stored packets are lost, and every output returns to its reset value immediately.

## Structure
- Package `s3g_pkg`: `START_BYTE` default, the `err_code` constants (ERR_CRC, ERR_LEN, ERR_TIMEOUT, ERR_OVERRUN), and the state enum.
- Sub-module `s3g_crc8`: byte-wise Maxim CRC-8 with `clear` and `update` inputs. It is shared with `s3g_tx`.
- Buffers are two register arrays, or one 2×`MAX_PAYLOAD` distributed RAM indexed by `{buf, addr}`.

## Test plan
- D5 01 00 00 -> `pkt_valid`=1 one cycle after the last byte; `pkt_len`=1; `rd_data`[0]=00; no error.
- D5 01 01 5E, then a second packet D5 01 00 00 before retire -> both stored; first retire shows 01 and `pkt_valid` stays high; second retire shows 00 and `pkt_valid` then drops.
- D5 01 01 00 -> `err_code`=0 pulse, `pkt_valid` stays 0.
- D5 21 with `MAX_PAYLOAD`=32 -> `err_code`=1; a following D5 01 00 00 is accepted.
- D5 01 then silence for `TIMEOUT_CYCLES` -> `err_code`=2, `busy` returns to 0.
- Two unretired good packets, then D5 02 AA BB xx -> `err_code`=3 after the 5th byte; stored packets intact. Also assert reset mid-payload -> all outputs at reset values.

Source files
------------

// File: rtl/s3g_pkg.sv
// Shared S3G definitions: start marker, receiver error codes, receiver states
// and the byte-wise Maxim CRC-8 step used by both rx and tx.
package s3g_pkg;

  localparam logic [7:0] START_BYTE_DEFAULT = 8'hD5;
  localparam logic [7:0] CRC8_POLY_REFL     = 8'h8C;

  localparam logic [1:0] ERR_CRC     = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC,
    ST_SKIP
  } rx_state_t;

  // Reflected CRC-8 (x^8+x^5+x^4+1), LSB first, one full byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC8_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_crc8.sv
// Running Maxim CRC-8 register; clear has priority over update.
module s3g_crc8
  import s3g_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       update,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  logic [7:0] crc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= 8'h00;
    end else if (clear) begin
      crc_reg <= 8'h00;
    end else if (update) begin
      crc_reg <= crc8_byte(crc_reg, data);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/s3g_rx_dbuf.sv
// Double-buffered S3G packet receiver: frames start/len/payload/CRC-8 packets
// into two ping-pong payload buffers and flags errors as one-cycle coded pulses.
module s3g_rx_dbuf
  import s3g_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 32,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] START_BYTE     = START_BYTE_DEFAULT,
  parameter int         AW             = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          pkt_valid,
  input  logic          pkt_ready,
  output logic [7:0]    pkt_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_valid,
  output logic [1:0]    err_code,
  output logic          busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_t        state_reg, state_next;
  logic [7:0]       len_reg, len_next;
  logic [7:0]       idx_reg, idx_next;
  logic             skip_hdr_reg, skip_hdr_next;
  logic             wr_bank_reg, wr_bank_next;
  logic             front_reg, front_next;
  logic [1:0]       full_reg, full_next;
  logic [1:0][7:0]  blen_reg, blen_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic             err_valid_reg, err_valid_next;
  logic [1:0]       err_code_reg, err_code_next;

  logic       wr_en, crc_clear, crc_update, retire, len_ok;
  logic [7:0] crc_val;
  logic [7:0] bank_rd [2];

  s3g_crc8 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (crc_clear),
    .update (crc_update),
    .data   (in_data),
    .crc    (crc_val)
  );

  // Payload storage is never reset; only the full flags say what is valid.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [7:0] mem [MAX_PAYLOAD];
      always_ff @(posedge clk) begin
        if (wr_en && (wr_bank_reg == 1'(gi))) begin
          mem[idx_reg[AW-1:0]] <= in_data;
        end
      end
      assign bank_rd[gi] = mem[rd_addr];
    end
  endgenerate

  assign retire = full_reg[front_reg] && pkt_ready;
  assign len_ok = (in_data != 8'd0) && (in_data <= 8'(MAX_PAYLOAD));

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    idx_next       = idx_reg;
    skip_hdr_next  = skip_hdr_reg;
    wr_bank_next   = wr_bank_reg;
    front_next     = front_reg;
    full_next      = full_reg;
    blen_next      = blen_reg;
    err_valid_next = 1'b0;
    err_code_next  = err_code_reg;
    wr_en          = 1'b0;
    crc_clear      = 1'b0;
    crc_update     = 1'b0;
    tmo_next       = (state_reg == ST_IDLE || in_valid) ? '0 : tmo_reg + 1'b1;

    if (retire) begin
      full_next[front_reg] = 1'b0;
      front_next           = ~front_reg;
    end

    if (in_valid) begin
      case (state_reg)
        ST_IDLE: begin
          if (in_data == START_BYTE) begin
            // Registered full flags: a buffer retired this cycle is not yet free.
            if (!(full_reg[0] && full_reg[1])) begin
              wr_bank_next = full_reg[front_reg] ? ~front_reg : front_reg;
              crc_clear    = 1'b1;
              state_next   = ST_LEN;
            end else begin
              skip_hdr_next = 1'b1;
              state_next    = ST_SKIP;
            end
          end
        end
        ST_LEN: begin
          if (!len_ok) begin
            err_valid_next = 1'b1;
            err_code_next  = ERR_LEN;
            state_next     = ST_IDLE;
          end else begin
            len_next   = in_data;
            idx_next   = 8'd0;
            state_next = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          wr_en      = 1'b1;
          crc_update = 1'b1;
          if (idx_reg == len_reg - 8'd1) begin
            state_next = ST_CRC;
          end else begin
            idx_next = idx_reg + 8'd1;
          end
        end
        ST_CRC: begin
          if (in_data == crc_val) begin
            full_next[wr_bank_reg] = 1'b1;
            blen_next[wr_bank_reg] = len_reg;
          end else begin
            err_valid_next = 1'b1;
            err_code_next  = ERR_CRC;
          end
          state_next = ST_IDLE;
        end
        ST_SKIP: begin
          // After the length byte, idx counts payload plus the trailing CRC byte.
          if (skip_hdr_reg) begin
            skip_hdr_next = 1'b0;
            if (!len_ok) begin
              err_valid_next = 1'b1;
              err_code_next  = ERR_OVERRUN;
              state_next     = ST_IDLE;
            end else begin
              len_next = in_data;
              idx_next = 8'd0;
            end
          end else if (idx_reg == len_reg) begin
            err_valid_next = 1'b1;
            err_code_next  = ERR_OVERRUN;
            state_next     = ST_IDLE;
          end else begin
            idx_next = idx_reg + 8'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (state_reg != ST_IDLE && tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      err_valid_next = 1'b1;
      err_code_next  = ERR_TIMEOUT;
      state_next     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      len_reg       <= 8'd0;
      idx_reg       <= 8'd0;
      skip_hdr_reg  <= 1'b0;
      wr_bank_reg   <= 1'b0;
      front_reg     <= 1'b0;
      full_reg      <= 2'b00;
      blen_reg      <= '0;
      tmo_reg       <= '0;
      err_valid_reg <= 1'b0;
      err_code_reg  <= ERR_CRC;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      idx_reg       <= idx_next;
      skip_hdr_reg  <= skip_hdr_next;
      wr_bank_reg   <= wr_bank_next;
      front_reg     <= front_next;
      full_reg      <= full_next;
      blen_reg      <= blen_next;
      tmo_reg       <= tmo_next;
      err_valid_reg <= err_valid_next;
      err_code_reg  <= err_code_next;
    end
  end

  assign pkt_valid = full_reg[front_reg];
  assign pkt_len   = pkt_valid ? blen_reg[front_reg] : 8'd0;
  assign rd_data   = bank_rd[front_reg];
  assign err_valid = err_valid_reg;
  assign err_code  = err_code_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_s3g_rx_dbuf.sv
// Directed bench for s3g_rx_dbuf: good packets, double buffering, CRC/length/
// timeout/overrun errors and asynchronous reset mid-payload.
module tb_s3g_rx_dbuf;

  localparam int MAXP = 32;
  localparam int TMO  = 40;
  localparam int AW   = 5;

  logic          clk;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [7:0]    pkt_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_valid;
  logic [1:0]    err_code;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  s3g_rx_dbuf #(
    .MAX_PAYLOAD    (MAXP),
    .TIMEOUT_CYCLES (TMO),
    .START_BYTE     (8'hD5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_len   (pkt_len),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .err_valid (err_valid),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Byte is consumed at the posedge between the two negedges; returns on the
  // negedge right after, where registered outputs of that byte are visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_pkt1(input logic [7:0] p, input logic [7:0] c);
    send_byte(8'hD5);
    send_byte(8'h01);
    send_byte(p);
    send_byte(c);
  endtask

  task automatic do_retire();
    @(negedge clk);
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
  endtask

  task automatic read_byte(input logic [AW-1:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " pkt_valid"}, 32'(pkt_valid), 32'd0);
    check_val({tag, " pkt_len"},   32'(pkt_len),   32'd0);
    check_val({tag, " err_valid"}, 32'(err_valid), 32'd0);
    check_val({tag, " err_code"},  32'(err_code),  32'd0);
    check_val({tag, " busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    logic [7:0] d;
    int waited;
    bit found;

    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    pkt_ready = 1'b0;
    rd_addr   = '0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single one-byte packet, payload 00, CRC 00.
    send_byte(8'hD5);
    send_byte(8'h01);
    check_val("t1 busy in len/payload", 32'(busy), 32'd1);
    send_byte(8'h00);
    check_val("t1 pkt_valid before crc", 32'(pkt_valid), 32'd0);
    send_byte(8'h00);
    check_val("t1 pkt_valid", 32'(pkt_valid), 32'd1);
    check_val("t1 pkt_len", 32'(pkt_len), 32'd1);
    check_val("t1 err_valid", 32'(err_valid), 32'd0);
    check_val("t1 busy idle", 32'(busy), 32'd0);
    read_byte('0, d);
    check_val("t1 rd_data[0]", 32'(d), 32'h00);
    do_retire();
    check_val("t1 pkt_valid after retire", 32'(pkt_valid), 32'd0);

    // Two queued packets: 01 (CRC 5E) then 00 (CRC 00).
    send_pkt1(8'h01, 8'h5E);
    send_pkt1(8'h00, 8'h00);
    check_val("t2 pkt_valid", 32'(pkt_valid), 32'd1);
    read_byte('0, d);
    check_val("t2 first rd_data", 32'(d), 32'h01);
    do_retire();
    check_val("t2 pkt_valid stays", 32'(pkt_valid), 32'd1);
    check_val("t2 second pkt_len", 32'(pkt_len), 32'd1);
    read_byte('0, d);
    check_val("t2 second rd_data", 32'(d), 32'h00);
    do_retire();
    check_val("t2 pkt_valid drops", 32'(pkt_valid), 32'd0);

    // CRC mismatch.
    send_pkt1(8'h01, 8'h00);
    check_val("t3 err_valid", 32'(err_valid), 32'd1);
    check_val("t3 err_code crc", 32'(err_code), 32'd0);
    check_val("t3 pkt_valid", 32'(pkt_valid), 32'd0);
    @(negedge clk);
    check_val("t3 err_valid one cycle", 32'(err_valid), 32'd0);

    // Length 0x21 exceeds MAX_PAYLOAD=32; next packet still accepted.
    send_byte(8'hD5);
    send_byte(8'h21);
    check_val("t4 err_valid", 32'(err_valid), 32'd1);
    check_val("t4 err_code len", 32'(err_code), 32'd1);
    check_val("t4 busy", 32'(busy), 32'd0);
    send_pkt1(8'h00, 8'h00);
    check_val("t4 recovery pkt_valid", 32'(pkt_valid), 32'd1);
    do_retire();

    // Timeout: the TMO-th idle cycle after the length byte aborts.
    send_byte(8'hD5);
    send_byte(8'h01);
    found  = 1'b0;
    waited = 0;
    for (int i = 1; i <= 3 * TMO && !found; i++) begin
      @(negedge clk);
      if (err_valid) begin
        found  = 1'b1;
        waited = i;
      end
    end
    check_val("t5 timeout seen", 32'(found), 32'd1);
    check_val("t5 timeout cycles", 32'(waited), 32'(TMO));
    check_val("t5 err_code timeout", 32'(err_code), 32'd2);
    check_val("t5 busy", 32'(busy), 32'd0);

    // Overrun: both buffers full, a 2-byte packet is skipped entirely.
    send_pkt1(8'h01, 8'h5E);
    send_pkt1(8'h00, 8'h00);
    send_byte(8'hD5);
    check_val("t6 busy in skip", 32'(busy), 32'd1);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check_val("t6 no err before crc byte", 32'(err_valid), 32'd0);
    send_byte(8'h33);
    check_val("t6 err_valid", 32'(err_valid), 32'd1);
    check_val("t6 err_code overrun", 32'(err_code), 32'd3);
    check_val("t6 busy", 32'(busy), 32'd0);
    check_val("t6 pkt_valid", 32'(pkt_valid), 32'd1);
    check_val("t6 pkt_len", 32'(pkt_len), 32'd1);
    read_byte('0, d);
    check_val("t6 front rd_data", 32'(d), 32'h01);

    // Async reset mid-payload clears everything, including err_code=3.
    do_retire();
    send_byte(8'hD5);
    send_byte(8'h02);
    send_byte(8'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t7 async reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_pkt1(8'h01, 8'h5E);
    check_val("t7 post-reset pkt_valid", 32'(pkt_valid), 32'd1);
    read_byte('0, d);
    check_val("t7 post-reset rd_data", 32'(d), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
